// File: rtl/mod_pkg.sv
// Shared definitions for the streaming modular accumulator.
//   DEFAULT_FIELD_WIDTH : default width of the modulus and field elements
//   DEFAULT_CNT_WIDTH   : default width of the per-group beat counter
//   state_t             : control FSM states (also exported as a debug port)
//   wide_sum_t          : one-bit-wider sum of two default-width field elements
package mod_pkg;

   localparam int DEFAULT_FIELD_WIDTH = 16;
   localparam int DEFAULT_CNT_WIDTH   = 8;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ACCUM = 2'd1,
      DRAIN = 2'd2,
      HOLD  = 2'd3
   } state_t;

   typedef logic [DEFAULT_FIELD_WIDTH:0] wide_sum_t;

endpackage

// File: rtl/mod_acc_if.sv
// Product-in / result-out handshake bundle of mod_acc.
//   in_valid/in_ready/in_data/in_last          : product beat stream
//   out_valid/out_ready/out_sum/out_count/out_sat : one result per group
// Handshake: a beat moves on a rising edge where in_valid && in_ready, a
// result moves where out_valid && out_ready. A source holds valid and its
// payload until the transfer; ready never depends combinationally on valid.
// The slave modport is the accumulator; the master modport is its environment.
interface mod_acc_if
   import mod_pkg::*;
#(
   parameter int FIELD_WIDTH = DEFAULT_FIELD_WIDTH,
   parameter int CNT_WIDTH   = DEFAULT_CNT_WIDTH
);

   logic                   in_valid;
   logic                   in_ready;
   logic [FIELD_WIDTH-1:0] in_data;
   logic                   in_last;
   logic                   out_valid;
   logic                   out_ready;
   logic [FIELD_WIDTH-1:0] out_sum;
   logic [CNT_WIDTH-1:0]   out_count;
   logic                   out_sat;

   modport slave (
      input  in_valid, in_data, in_last, out_ready,
      output in_ready, out_valid, out_sum, out_count, out_sat
   );

   modport master (
      output in_valid, in_data, in_last, out_ready,
      input  in_ready, out_valid, out_sum, out_count, out_sat
   );

endinterface

// File: rtl/mod_add_reduce.sv
// Combinational (a + b) mod s with a single conditional subtraction.
//   a, b : operands; correct whenever a + b < 2s (e.g. a, b < s, or b = 0
//          and a < 2s)
//   s    : modulus
//   y    : reduced result, < s under the above condition
module mod_add_reduce #(
   parameter int FIELD_WIDTH = 16
) (
   input  logic [FIELD_WIDTH-1:0] a,
   input  logic [FIELD_WIDTH-1:0] b,
   input  logic [FIELD_WIDTH-1:0] s,
   output logic [FIELD_WIDTH-1:0] y
);

   logic [FIELD_WIDTH:0] t;

   assign t = {1'b0, a} + {1'b0, b};

   always_comb begin
      if (t >= {1'b0, s}) y = FIELD_WIDTH'(t - {1'b0, s});
      else                y = t[FIELD_WIDTH-1:0];
   end

endmodule

// File: rtl/mod_acc.sv
// Streaming modular accumulator behind the Barrett multiplier.
// Each product beat (< 2s) is fully reduced (stage 1), added into the group
// accumulator mod s (stage 2), and one result is emitted per in_last group.
//   clk       : rising-edge clock
//   reset     : asynchronous, active-low
//   s         : modulus, sampled on the first beat of each group
//   bus       : slave side of mod_acc_if (beat input, result output)
//   dbg_state : current control state
module mod_acc
   import mod_pkg::*;
#(
   parameter int FIELD_WIDTH = DEFAULT_FIELD_WIDTH,
   parameter int CNT_WIDTH   = DEFAULT_CNT_WIDTH
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic [FIELD_WIDTH-1:0] s,
   mod_acc_if.slave               bus,
   output state_t                 dbg_state
);

   localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

   state_t                 state;
   logic [FIELD_WIDTH-1:0] s_lat;
   logic [FIELD_WIDTH-1:0] s_eff;
   logic [FIELD_WIDTH-1:0] x_red;
   logic [FIELD_WIDTH-1:0] acc;
   logic [FIELD_WIDTH-1:0] acc_next;
   logic [FIELD_WIDTH-1:0] s1_x;
   logic                   s1_v;
   logic                   s1_last;
   logic                   s2_done;
   logic                   retired;
   logic [CNT_WIDTH-1:0]   count;
   logic [CNT_WIDTH-1:0]   count_inc;
   logic                   in_ready_q;
   logic                   out_valid_q;
   logic [FIELD_WIDTH-1:0] out_sum_q;
   logic [CNT_WIDTH-1:0]   out_count_q;
   logic                   out_sat_q;
   logic                   beat;
   logic                   grp_clear;

   assign beat      = bus.in_valid && in_ready_q;
   assign grp_clear = (state == HOLD) && bus.out_ready;
   assign count_inc = (count == CNT_MAX) ? count : count + 1'b1;

   // The first beat of a group is reduced before s_lat has been loaded, so it
   // uses the live modulus; every later beat uses the latched one.
   assign s_eff = (state == IDLE) ? s : s_lat;

   mod_add_reduce #(.FIELD_WIDTH(FIELD_WIDTH)) u_stage1 (
      .a (bus.in_data),
      .b ({FIELD_WIDTH{1'b0}}),
      .s (s_eff),
      .y (x_red)
   );

   mod_add_reduce #(.FIELD_WIDTH(FIELD_WIDTH)) u_stage2 (
      .a (acc),
      .b (s1_x),
      .s (s_lat),
      .y (acc_next)
   );

   // Datapath: stage 1 holds the reduced beat, stage 2 is the accumulator.
   // s2_done pulses when acc has absorbed the last beat; retired follows one
   // cycle later and is what releases the result load in DRAIN.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         s1_v    <= 1'b0;
         s1_last <= 1'b0;
         s1_x    <= '0;
         s2_done <= 1'b0;
         retired <= 1'b0;
         acc     <= '0;
      end else begin
         s1_v    <= beat;
         s2_done <= s1_v && s1_last;
         retired <= s2_done;
         if (beat) begin
            s1_x    <= x_red;
            s1_last <= bus.in_last;
         end
         if (grp_clear)  acc <= '0;
         else if (s1_v)  acc <= acc_next;
      end
   end

   // Control FSM with registered handshake and result outputs.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state       <= IDLE;
         in_ready_q  <= 1'b0;
         out_valid_q <= 1'b0;
         out_sum_q   <= '0;
         out_count_q <= '0;
         out_sat_q   <= 1'b0;
         count       <= '0;
         s_lat       <= '0;
      end else begin
         if (beat) count <= count_inc;
         case (state)
            IDLE: begin
               // Raising in_ready here also brings it up after reset.
               in_ready_q <= 1'b1;
               if (beat) begin
                  s_lat <= s;
                  if (bus.in_last) begin
                     state      <= DRAIN;
                     in_ready_q <= 1'b0;
                  end else begin
                     state <= ACCUM;
                  end
               end
            end
            ACCUM: begin
               if (beat && bus.in_last) begin
                  state      <= DRAIN;
                  in_ready_q <= 1'b0;
               end
            end
            DRAIN: begin
               if (retired) begin
                  out_sum_q   <= acc;
                  out_count_q <= count;
                  out_sat_q   <= (count == CNT_MAX);
                  out_valid_q <= 1'b1;
                  state       <= HOLD;
               end
            end
            HOLD: begin
               if (bus.out_ready) begin
                  out_valid_q <= 1'b0;
                  count       <= '0;
                  in_ready_q  <= 1'b1;
                  state       <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign bus.in_ready  = in_ready_q;
   assign bus.out_valid = out_valid_q;
   assign bus.out_sum   = out_sum_q;
   assign bus.out_count = out_count_q;
   assign bus.out_sat   = out_sat_q;
   assign dbg_state     = state;

endmodule
